// File: rtl/green_led_driver.sv
// PWM/blink output stage for the green-LED PIO: shadows the software pattern at
// PWM-period boundaries and drives registered LED pins with brightness and blink.
module green_led_driver #(
   parameter int LED_WIDTH     = 9,
   parameter int PRESCALE      = 50,
   parameter int BLINK_PERIODS = 1953
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [LED_WIDTH-1:0] led_pattern,
   input  logic [LED_WIDTH-1:0] blink_mask,
   input  logic [7:0]           duty,
   input  logic                 lamp_test,
   output logic [LED_WIDTH-1:0] leds,
   output logic                 period_start,
   output logic                 blink_phase
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIODS - 1);

   logic [PW-1:0]        r_presc_cnt;
   logic [7:0]           r_pwm_cnt;
   logic [BW-1:0]        r_blink_cnt;
   logic [LED_WIDTH-1:0] r_pattern_q;
   logic [LED_WIDTH-1:0] r_blink_q;
   logic [7:0]           r_duty_q;
   logic                 r_blink_phase;
   logic [LED_WIDTH-1:0] r_leds;
   logic                 r_period_start;

   logic                 w_step_tick;
   logic                 w_boundary;
   logic                 w_pwm_on;
   logic [LED_WIDTH-1:0] w_leds_next;

   // With PRESCALE == 1 the counter is stuck at 0 == PRESC_MAX, so every cycle is a step.
   assign w_step_tick = (r_presc_cnt == PRESC_MAX);
   assign w_boundary  = w_step_tick && (r_pwm_cnt == 8'hFF);
   assign w_pwm_on    = (r_duty_q == 8'hFF) || (r_pwm_cnt < r_duty_q);

   always_comb begin
      w_leds_next = '0;
      if (lamp_test) begin
         w_leds_next = '1;
      end else begin
         w_leds_next = r_pattern_q & {LED_WIDTH{w_pwm_on}} &
                       (~r_blink_q | {LED_WIDTH{r_blink_phase}});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc_cnt <= '0;
         r_pwm_cnt   <= '0;
      end else begin
         r_presc_cnt <= w_step_tick ? '0 : r_presc_cnt + 1'b1;
         if (w_step_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
         end
      end
   end

   // Shadow load, blink advance and pwm wrap all commit on the same boundary edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pattern_q   <= '0;
         r_blink_q     <= '0;
         r_duty_q      <= '0;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (w_boundary) begin
         r_pattern_q <= led_pattern;
         r_blink_q   <= blink_mask;
         r_duty_q    <= duty;
         if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_leds         <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_leds         <= w_leds_next;
         r_period_start <= w_boundary;
      end
   end

   assign leds         = r_leds;
   assign period_start = r_period_start;
   assign blink_phase  = r_blink_phase;

endmodule

// File: tb/tb_green_led_driver.sv
// Directed bench for green_led_driver at PRESCALE=2, BLINK_PERIODS=2 (512-cycle
// period, blink toggles every 1024 cycles); cyc counts clock edges since reset release.
module tb_green_led_driver;

   logic       clk;
   logic       reset;
   logic [8:0] led_pattern;
   logic [8:0] blink_mask;
   logic [7:0] duty;
   logic       lamp_test;
   logic [8:0] leds;
   logic       period_start;
   logic       blink_phase;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   green_led_driver #(
      .LED_WIDTH    (9),
      .PRESCALE     (2),
      .BLINK_PERIODS(2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .led_pattern (led_pattern),
      .blink_mask  (blink_mask),
      .duty        (duty),
      .lamp_test   (lamp_test),
      .leds        (leds),
      .period_start(period_start),
      .blink_phase (blink_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Blink phase after m edges: starts at 1, toggles at every 1024th edge.
   function automatic logic phase_at(input int m);
      return ((m / 1024) % 2) == 0;
   endfunction

   // One clock edge, then check the period marker and blink phase.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      check("period_start", 32'(period_start), 32'((cyc % 512) == 0));
      check("blink_phase", 32'(blink_phase), 32'(phase_at(cyc)));
   endtask

   function automatic logic [8:0] blink_leds(input int m);
      return phase_at(m) ? 9'h1FF : 9'h1FC;
   endfunction

   initial begin
      logic [8:0] exp;
      reset       = 1'b1;
      led_pattern = 9'h1FF;
      blink_mask  = 9'h000;
      duty        = 8'hFF;
      lamp_test   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_leds", 32'(leds), 32'h0);
      check("reset_period_start", 32'(period_start), 32'h0);
      check("reset_blink_phase", 32'(blink_phase), 32'h1);
      reset = 1'b0;
      cyc   = 0;

      // Full-on pattern: dark until the first boundary is through the output register.
      while (cyc < 600) begin
         step();
         exp = (cyc >= 513) ? 9'h1FF : 9'h000;
         check("first_load", 32'(leds), 32'(exp));
      end

      // Mid-period write: ignored until the boundary at edge 1024.
      led_pattern = 9'h0A5;
      duty        = 8'd64;
      while (cyc < 1024) begin
         step();
         check("hold_old_shadow", 32'(leds), 32'h1FF);
      end

      // duty=64: 128 cycles lit, 384 dark; duty=0 written at 2100 takes effect at 2560.
      while (cyc < 2560) begin
         step();
         if (cyc == 2100) duty = 8'd0;
         exp = (((cyc - 1) % 512) < 128) ? 9'h0A5 : 9'h000;
         check("duty64", 32'(leds), 32'(exp));
      end

      // duty=0 dark; duty=255 written mid-period appears only after the next boundary.
      while (cyc < 3700) begin
         step();
         if (cyc == 2800) duty = 8'hFF;
         exp = (cyc <= 3072) ? 9'h000 : 9'h0A5;
         check("duty0_then_full", 32'(leds), 32'(exp));
      end

      // Blink bits [1:0] follow the previous cycle's blink phase; others stay lit.
      led_pattern = 9'h1FF;
      blink_mask  = 9'h003;
      duty        = 8'hFF;
      while (cyc < 6200) begin
         step();
         exp = (cyc <= 4096) ? 9'h0A5 : blink_leds(cyc - 1);
         check("blink", 32'(leds), 32'(exp));
      end

      // duty=0 from edge 6656, with a 10-cycle lamp test overriding it.
      duty = 8'd0;
      while (cyc < 7300) begin
         step();
         if (cyc == 6800) lamp_test = 1'b1;
         if (cyc == 6810) lamp_test = 1'b0;
         if (cyc >= 6801 && cyc <= 6810) exp = 9'h1FF;
         else if (cyc <= 6656)           exp = blink_leds(cyc - 1);
         else                            exp = 9'h000;
         check("lamp_test", 32'(leds), 32'(exp));
      end

      led_pattern = 9'h0A5;
      blink_mask  = 9'h000;
      duty        = 8'hFF;
      while (cyc < 7800) begin
         step();
         exp = (cyc <= 7680) ? 9'h000 : 9'h0A5;
         check("pre_reset", 32'(leds), 32'(exp));
      end

      // Asynchronous reset between clock edges.
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_leds", 32'(leds), 32'h0);
      check("async_reset_blink_phase", 32'(blink_phase), 32'h1);
      check("async_reset_period_start", 32'(period_start), 32'h0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
      while (cyc < 520) begin
         step();
         exp = (cyc >= 513) ? 9'h0A5 : 9'h000;
         check("after_reset", 32'(leds), 32'(exp));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
